// File: rtl/a5_pkg.sv
// rtl/a5_pkg.sv - shared constants, state encoding and output decode for the A5/1 keystream sequencer
//
// Purpose: phase lengths, the sequencer state enum and the per-state output
//          decode used by a5_keystream_sequencer and a5_burst_capture.
// Ports:   none (package).
// Build option: A5_ABORT_EN - when defined, a new start is also accepted in
//          KEY, MIX, GEN, OUT0 and OUT1 and aborts the frame in progress.
package a5_pkg;

    localparam int KEY_BITS   = 64;
    localparam int FRAME_BITS = 22;
    localparam int MIX_CYCLES = 100;
    localparam int BURST_BITS = 114;

    // Key+frame shift-in enables, and keystream enables per frame.
    localparam int LOAD_CLKS = KEY_BITS + FRAME_BITS;
    localparam int GEN_CLKS  = 2 * BURST_BITS;

    // Wide enough for the longest phase (GEN_CLKS - 1 = 227).
    localparam int CNT_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KEY,
        ST_MIX,
        ST_GEN,
        ST_DRAIN,
        ST_OUT0,
        ST_OUT1
    } state_t;

    typedef struct packed {
        logic load;
        logic clk_en;
        logic valid;
        logic dir;
        logic busy;
        logic ready;
    } ctrl_t;

    // Output levels for the cycle spent in state s. The sequencer registers
    // this value from its next state so every output comes straight off a flop.
    function automatic ctrl_t ctrl_for(state_t s);
        ctrl_t c;
        c        = '0;
        c.load   = (s == ST_LOAD);
        c.clk_en = (s == ST_KEY) || (s == ST_MIX) || (s == ST_GEN);
        c.valid  = (s == ST_OUT0) || (s == ST_OUT1);
        c.dir    = (s == ST_OUT1);
        c.busy   = (s != ST_IDLE);
`ifdef A5_ABORT_EN
        c.ready  = (s == ST_IDLE) || (s == ST_KEY) || (s == ST_MIX) ||
                   (s == ST_GEN)  || (s == ST_OUT0) || (s == ST_OUT1);
`else
        c.ready  = (s == ST_IDLE);
`endif
        return c;
    endfunction

endpackage

// File: rtl/a5_burst_capture.sv
// rtl/a5_burst_capture.sv - serial keystream capture into two 114-bit bursts
//
// Purpose: samples the generator output one cycle after each GEN-phase enable,
//          shifting captures 1..114 into burst 0 and 115..228 into burst 1,
//          first-captured bit ending in the MSB. Bursts hold once full.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : new frame accepted; drop flag, count and both bursts
//   in_gen       : sequencer is in GEN this cycle
//   d            : generator serial output
//   sel_dir      : 0 presents burst 0 (downlink), 1 presents burst 1 (uplink)
//   burst        : selected burst
module a5_burst_capture
    import a5_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  in_gen,
    input  logic                  d,
    input  logic                  sel_dir,
    output logic [BURST_BITS-1:0] burst
);

    logic                  flag;
    logic [7:0]            n_cap;
    logic [BURST_BITS-1:0] b0;
    logic [BURST_BITS-1:0] b1;

    // flag lags GEN by one cycle: the generator's d reflects the enable of the
    // previous cycle, so the last capture lands in DRAIN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag  <= 1'b0;
            n_cap <= '0;
            b0    <= '0;
            b1    <= '0;
        end else if (clear) begin
            flag  <= 1'b0;
            n_cap <= '0;
            b0    <= '0;
            b1    <= '0;
        end else begin
            flag <= in_gen;
            if (flag) begin
                if (n_cap < 8'(BURST_BITS)) begin
                    b0 <= {b0[BURST_BITS-2:0], d};
                end else begin
                    b1 <= {b1[BURST_BITS-2:0], d};
                end
                n_cap <= n_cap + 8'd1;
            end
        end
    end

    assign burst = sel_dir ? b1 : b0;

endmodule

// File: rtl/a5_keystream_sequencer.sv
// rtl/a5_keystream_sequencer.sv - load/mix/generate sequencing and burst output for an A5/1 generator
//
// Purpose: accepts key+frame on start, drives the generator through LOAD (1),
//          KEY (86), MIX (100), GEN (228) and DRAIN (1) cycles, then offers the
//          downlink and uplink bursts over a valid/ready handshake.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   start, ready_in      : frame request, accepted when start && ready_in
//   key_in, frame_in     : session key and frame number, sampled on accept
//   gen_load, gen_clk_en : generator load and lfsr clock enable
//   gen_key, gen_frame   : registered key/frame to the generator
//   gen_d                : generator serial output
//   ks_valid, ks_ready   : burst handshake
//   ks_burst, ks_dir     : burst data (first bit in MSB), 0 = downlink / 1 = uplink
//   busy                 : high outside IDLE
// Build option: A5_ABORT_EN (see a5_pkg) allows start to abort a running frame.
module a5_keystream_sequencer
    import a5_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  ready_in,
    input  logic [KEY_BITS-1:0]   key_in,
    input  logic [FRAME_BITS-1:0] frame_in,
    output logic                  gen_load,
    output logic [KEY_BITS-1:0]   gen_key,
    output logic [FRAME_BITS-1:0] gen_frame,
    output logic                  gen_clk_en,
    input  logic                  gen_d,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic [BURST_BITS-1:0] ks_burst,
    output logic                  ks_dir,
    output logic                  busy
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] phase_len;
    ctrl_t            ctrl;
    logic             accept;
    logic             in_gen;

    assign accept = start && ctrl.ready;
    assign in_gen = (state == ST_GEN);

    // The down-counter is loaded with (length - 1) on phase entry so the
    // phase leaves on the cycle it reads 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (accept) begin
            // An accept in an OUT state also completes any same-cycle
            // handshake; the new frame takes priority.
            state_nxt = ST_LOAD;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_LOAD: begin
                    state_nxt = ST_KEY;
                    cnt_nxt   = CNT_W'(LOAD_CLKS - 1);
                end
                ST_KEY: begin
                    if (cnt == '0) begin
                        state_nxt = ST_MIX;
                        cnt_nxt   = CNT_W'(MIX_CYCLES - 1);
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_MIX: begin
                    if (cnt == '0) begin
                        state_nxt = ST_GEN;
                        cnt_nxt   = CNT_W'(GEN_CLKS - 1);
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_GEN: begin
                    if (cnt == '0) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_DRAIN: state_nxt = ST_OUT0;
                ST_OUT0:  if (ks_ready) state_nxt = ST_OUT1;
                ST_OUT1:  if (ks_ready) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ctrl      <= ctrl_for(ST_IDLE);
            gen_key   <= '0;
            gen_frame <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ctrl  <= ctrl_for(state_nxt);
            if (accept) begin
                gen_key   <= key_in;
                gen_frame <= frame_in;
            end
        end
    end

    // Cycles spent in the current state; checked against the phase length
    // whenever a timed phase exits normally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_len <= '0;
        end else begin
            phase_len <= (state_nxt != state) ? CNT_W'(1) : phase_len + CNT_W'(1);
            if (state_nxt != state && !accept) begin
                case (state)
                    ST_LOAD:  assert (phase_len == CNT_W'(1))
                                  else $error("LOAD lasted %0d cycles", phase_len);
                    ST_KEY:   assert (phase_len == CNT_W'(LOAD_CLKS))
                                  else $error("KEY lasted %0d cycles", phase_len);
                    ST_MIX:   assert (phase_len == CNT_W'(MIX_CYCLES))
                                  else $error("MIX lasted %0d cycles", phase_len);
                    ST_GEN:   assert (phase_len == CNT_W'(GEN_CLKS))
                                  else $error("GEN lasted %0d cycles", phase_len);
                    ST_DRAIN: assert (phase_len == CNT_W'(1))
                                  else $error("DRAIN lasted %0d cycles", phase_len);
                    default: ;
                endcase
            end
        end
    end

    a5_burst_capture u_capture (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .in_gen  (in_gen),
        .d       (gen_d),
        .sel_dir (ctrl.dir),
        .burst   (ks_burst)
    );

    assign ready_in   = ctrl.ready;
    assign gen_load   = ctrl.load;
    assign gen_clk_en = ctrl.clk_en;
    assign ks_valid   = ctrl.valid;
    assign ks_dir     = ctrl.dir;
    assign busy       = ctrl.busy;

endmodule
